// File: rtl/frame_buffer_8x8_if.sv
// Pixel-write handshake bus for frame_buffer_8x8.
// The producer drives address/colour with wr_valid; the buffer answers with wr_ready.
interface frame_buffer_8x8_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_x;
    logic [2:0] wr_y;
    logic [2:0] wr_rgb;

    modport master (output wr_valid, wr_x, wr_y, wr_rgb, input  wr_ready);
    modport slave  (input  wr_valid, wr_x, wr_y, wr_rgb, output wr_ready);
endinterface

// File: rtl/frame_buffer_8x8.sv
// Double-buffered 8x8 RGB frame buffer. Pixels are drawn into the back bank, which is
// swapped to the display at a frame boundary and then refreshed from the new front bank.
module frame_buffer_8x8 (
    input  logic                clk,
    input  logic                reset_n,
    frame_buffer_8x8_if.slave   wr,
    input  logic                clear_req,
    input  logic                commit_req,
    input  logic [2:0]          col_num,
    input  logic                col_data_capture,
    output logic [7:0]          red_vect_out,
    output logic [7:0]          green_vect_out,
    output logic [7:0]          blue_vect_out,
    output logic                busy,
    output logic                swapped
);

    typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP, COPY} state_t;

    // One display column; bit 7 of each plane is the top line.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } col_t;

    state_t            state_q, state_d;
    col_t [1:0][7:0]   mem;
    logic              front_sel;
    logic              back_sel;
    logic [2:0]        col_cnt;
    logic              frame_end;
    logic              wr_fire;
    col_t              front_col;

    assign back_sel    = ~front_sel;
    assign frame_end   = col_data_capture && (col_num == 3'd7);
    assign wr.wr_ready = (state_q == IDLE) && !clear_req && !commit_req;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign busy        = (state_q != IDLE);

    assign front_col      = mem[front_sel][col_num];
    assign red_vect_out   = front_col.r;
    assign green_vect_out = front_col.g;
    assign blue_vect_out  = front_col.b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                end else if (commit_req) begin
                    state_d = WAIT_SWAP;
                end
            end
            CLEAR:     if (col_cnt == 3'd7) state_d = IDLE;
            WAIT_SWAP: if (frame_end)       state_d = COPY;
            COPY:      if (col_cnt == 3'd7) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: the banks are flops, not RAM, so they can be reset; the display must read zeros as soon as reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem       <= '0;
            front_sel <= 1'b0;
            swapped   <= 1'b0;
            col_cnt   <= 3'd0;
        end else begin
            swapped <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wr_fire) begin
                        // Line y lives at bit (7-y), which for a 3-bit index is ~y.
                        mem[back_sel][wr.wr_x].r[~wr.wr_y] <= wr.wr_rgb[2];
                        mem[back_sel][wr.wr_x].g[~wr.wr_y] <= wr.wr_rgb[1];
                        mem[back_sel][wr.wr_x].b[~wr.wr_y] <= wr.wr_rgb[0];
                    end
                end
                CLEAR: begin
                    mem[back_sel][col_cnt] <= '0;
                    col_cnt                <= col_cnt + 3'd1;
                end
                WAIT_SWAP: begin
                    if (frame_end) begin
                        front_sel <= ~front_sel;
                        swapped   <= 1'b1;
                    end
                end
                COPY: begin
                    // front_sel has already toggled, so this refreshes the old front from the new one.
                    mem[back_sel][col_cnt] <= mem[front_sel][col_cnt];
                    col_cnt                <= col_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_8x8.sv
// Directed bench for frame_buffer_8x8: a bank model predicts each committed image, which
// is queued at commit time and compared column by column when the swap appears.
module tb_frame_buffer_8x8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } col_t;

    typedef logic [191:0] img_t;

    logic       clk;
    logic       reset_n;
    logic       clear_req;
    logic       commit_req;
    logic [2:0] col_num;
    logic       col_data_capture;
    logic [7:0] red_vect_out;
    logic [7:0] green_vect_out;
    logic [7:0] blue_vect_out;
    logic       busy;
    logic       swapped;

    frame_buffer_8x8_if wr_bus ();

    frame_buffer_8x8 dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wr               (wr_bus),
        .clear_req        (clear_req),
        .commit_req       (commit_req),
        .col_num          (col_num),
        .col_data_capture (col_data_capture),
        .red_vect_out     (red_vect_out),
        .green_vect_out   (green_vect_out),
        .blue_vect_out    (blue_vect_out),
        .busy             (busy),
        .swapped          (swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    col_t m_front [8];
    col_t m_back  [8];
    img_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] disp();
        return {red_vect_out, green_vect_out, blue_vect_out};
    endfunction

    function automatic img_t pack_back();
        img_t img;
        for (int c = 0; c < 8; c++) img[c*24 +: 24] = m_back[c];
        return img;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 8; c++) begin
            m_front[c] = '0;
            m_back[c]  = '0;
        end
        exp_q.delete();
    endtask

    task automatic write_px(input logic [2:0] x, input logic [2:0] y, input logic [2:0] rgb);
        int yi;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_x     = x;
        wr_bus.wr_y     = y;
        wr_bus.wr_rgb   = rgb;
        #1;
        check("wr_ready_on_write", 32'(wr_bus.wr_ready), 32'd1);
        @(negedge clk);
        wr_bus.wr_valid = 1'b0;
        yi = 7 - int'(y);
        m_back[x].r[yi] = rgb[2];
        m_back[x].g[yi] = rgb[1];
        m_back[x].b[yi] = rgb[0];
    endtask

    // Issue commit (optionally on a frame_end cycle), then sit in WAIT_SWAP for 8 cycles.
    task automatic commit(input bit with_fe);
        commit_req = 1'b1;
        if (with_fe) begin
            col_num          = 3'd7;
            col_data_capture = 1'b1;
        end
        #1;
        check("commit_wr_ready", 32'(wr_bus.wr_ready), 32'd0);
        check("commit_busy", 32'(busy), 32'd0);
        exp_q.push_back(pack_back());
        @(negedge clk);
        commit_req       = 1'b0;
        col_data_capture = 1'b0;
        for (int k = 0; k < 8; k++) begin
            col_num = 3'(k);
            #1;
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_swapped", 32'(swapped), 32'd0);
            check("wait_front_kept", 32'(disp()), 32'(m_front[k]));
            @(negedge clk);
        end
    endtask

    // Frame end in WAIT_SWAP at cycle s; COPY occupies s+1..s+8. abort_at=k pulls reset at s+k.
    task automatic do_swap(input int abort_at);
        img_t img;
        col_num          = 3'd7;
        col_data_capture = 1'b1;
        #1;
        check("swap_s_swapped", 32'(swapped), 32'd0);
        check("swap_s_busy", 32'(busy), 32'd1);
        @(negedge clk);
        col_data_capture = 1'b0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        img = exp_q.pop_front();
        for (int c = 0; c < 8; c++) m_front[c] = img[c*24 +: 24];
        for (int k = 1; k <= 8; k++) begin
            col_num = 3'(k - 1);
            if (k == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_swapped", 32'(swapped), 32'd0);
                check("rst_disp", 32'(disp()), 32'd0);
                col_num = 3'd2;
                #1;
                check("rst_disp_col2", 32'(disp()), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
                #1;
                check("rel_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
                check("rel_busy", 32'(busy), 32'd0);
                check("rel_disp", 32'(disp()), 32'd0);
                model_reset();
                @(negedge clk);
                return;
            end
            #1;
            check("copy_swapped", 32'(swapped), 32'(k == 1));
            check("copy_busy", 32'(busy), 32'd1);
            check("copy_wr_ready", 32'(wr_bus.wr_ready), 32'd0);
            check("new_front", 32'(disp()), 32'(m_front[k-1]));
            @(negedge clk);
        end
        #1;
        check("s9_busy", 32'(busy), 32'd0);
        check("s9_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
        check("s9_swapped", 32'(swapped), 32'd0);
        for (int c = 0; c < 8; c++) m_back[c] = m_front[c];
    endtask

    task automatic check_col(input string tag, input logic [2:0] c, input logic [23:0] exp);
        col_num = c;
        #1;
        check(tag, 32'(disp()), 32'(exp));
    endtask

    initial begin
        reset_n          = 1'b0;
        clear_req        = 1'b0;
        commit_req       = 1'b0;
        col_num          = 3'd0;
        col_data_capture = 1'b0;
        wr_bus.wr_valid  = 1'b0;
        wr_bus.wr_x      = 3'd0;
        wr_bus.wr_y      = 3'd0;
        wr_bus.wr_rgb    = 3'd0;
        model_reset();

        repeat (3) @(negedge clk);
        check("in_reset_busy", 32'(busy), 32'd0);
        check("in_reset_disp", 32'(disp()), 32'd0);
        reset_n = 1'b1;
        #1;
        check("post_reset_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_swapped", 32'(swapped), 32'd0);
        @(negedge clk);

        // First image: two pixels, displayed only after the frame end.
        write_px(3'd2, 3'd0, 3'b100);
        write_px(3'd5, 3'd3, 3'b011);
        commit(1'b0);
        do_swap(0);
        check_col("first_col2", 3'd2, {8'h80, 8'h00, 8'h00});
        check_col("first_col5", 3'd5, {8'h00, 8'h10, 8'h10});
        @(negedge clk);

        // Second image builds on the copied back bank.
        write_px(3'd0, 3'd7, 3'b001);
        commit(1'b0);
        do_swap(0);
        check_col("second_col0", 3'd0, {8'h00, 8'h00, 8'h01});
        check_col("second_col2_kept", 3'd2, {8'h80, 8'h00, 8'h00});
        @(negedge clk);

        // Clear and commit together: clear wins, commit and the write are dropped.
        clear_req        = 1'b1;
        commit_req       = 1'b1;
        wr_bus.wr_valid  = 1'b1;
        wr_bus.wr_x      = 3'd7;
        wr_bus.wr_y      = 3'd7;
        wr_bus.wr_rgb    = 3'b111;
        #1;
        check("clr_wr_ready", 32'(wr_bus.wr_ready), 32'd0);
        check("clr_busy_c0", 32'(busy), 32'd0);
        @(negedge clk);
        clear_req       = 1'b0;
        commit_req      = 1'b0;
        wr_bus.wr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            col_num          = 3'(k - 1);
            col_data_capture = 1'b0;
            #1;
            check("clr_busy", 32'(busy), 32'd1);
            check("clr_swapped", 32'(swapped), 32'd0);
            check("clr_front_kept", 32'(disp()), 32'(m_front[k-1]));
            if (k == 4) begin
                col_num          = 3'd7;
                col_data_capture = 1'b1;
            end
            @(negedge clk);
        end
        col_data_capture = 1'b0;
        #1;
        check("clr_done_busy", 32'(busy), 32'd0);
        check("clr_done_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
        for (int c = 0; c < 8; c++) m_back[c] = '0;
        col_num          = 3'd7;
        col_data_capture = 1'b1;
        @(negedge clk);
        col_data_capture = 1'b0;
        #1;
        check("idle_fe_no_swap", 32'(swapped), 32'd0);
        check("idle_fe_busy", 32'(busy), 32'd0);
        @(negedge clk);

        write_px(3'd4, 3'd4, 3'b111);
        commit(1'b0);
        do_swap(0);
        check_col("after_clear_col4", 3'd4, {8'h08, 8'h08, 8'h08});
        check_col("after_clear_col2", 3'd2, 24'h0);
        @(negedge clk);

        // Commit on a frame-end cycle waits for the next frame end.
        write_px(3'd1, 3'd1, 3'b010);
        commit(1'b1);
        do_swap(0);
        check_col("late_swap_col1", 3'd1, {8'h00, 8'h40, 8'h00});
        @(negedge clk);

        // Reset during COPY at s+4, then a normal write/commit afterwards.
        write_px(3'd6, 3'd6, 3'b110);
        commit(1'b0);
        do_swap(4);
        write_px(3'd3, 3'd2, 3'b101);
        commit(1'b0);
        do_swap(0);
        check_col("post_rst_col3", 3'd3, {8'h20, 8'h00, 8'h20});
        check_col("post_rst_col6", 3'd6, 24'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
